// File: rtl/dest_reg_pipe.sv
// ============================================================================
// dest_reg_pipe : write-back destination select, STAGES-deep pipe, RAW hazard flags
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dest_reg_pipe #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31,
  parameter int DIST_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        reg_dst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_chk,
  input  logic [ADDR_W-1:0] rt_chk,
  output logic [ADDR_W-1:0] dest_out,
  output logic              we_out,
  output logic              valid_out,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [DIST_W-1:0] dist_rs,
  output logic [DIST_W-1:0] dist_rt
);

  localparam logic [1:0] SEL_RT   = 2'b00;
  localparam logic [1:0] SEL_RD   = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // index 0 is stage 1 (youngest), index STAGES-1 is the write-back stage
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             we_q, we_d;
  logic [STAGES-1:0][ADDR_W-1:0] dest_q, dest_d;

  logic [ADDR_W-1:0] dest_sel;
  logic [ADDR_W-1:0] cap_dest;
  logic              cap_we;

  always_comb begin
    dest_sel = '0;
    case (reg_dst)
      SEL_RT:   dest_sel = rt;
      SEL_RD:   dest_sel = rd;
      SEL_LINK: dest_sel = ADDR_W'(LINK_REG);
      default:  dest_sel = '0;
    endcase
    cap_we   = valid_in & reg_write & (reg_dst != SEL_NONE) & (dest_sel != '0);
    cap_dest = valid_in ? dest_sel : '0;
  end

  // flush overrides stall for stage 1 only; older stages still drain
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    dest_d  = dest_q;
    if (flush || !stall) begin
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      if (flush) begin
        valid_d[0] = 1'b0;
        we_d[0]    = 1'b0;
        dest_d[0]  = '0;
      end else begin
        valid_d[0] = valid_in;
        we_d[0]    = cap_we;
        dest_d[0]  = cap_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
    end
  end

  assign dest_out  = dest_q[STAGES-1];
  assign we_out    = we_q[STAGES-1];
  assign valid_out = valid_q[STAGES-1];

  // scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    dist_rs   = '0;
    dist_rt   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && (dest_q[k] == rs_chk) && (rs_chk != '0)) begin
        hazard_rs = 1'b1;
        dist_rs   = DIST_W'(k + 1);
      end
      if (valid_q[k] && we_q[k] && (dest_q[k] == rt_chk) && (rt_chk != '0)) begin
        hazard_rt = 1'b1;
        dist_rt   = DIST_W'(k + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dest_reg_pipe.sv
// ============================================================================
// tb_dest_reg_pipe : table vectors plus hand sequences, queue scoreboard
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dest_reg_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic [4:0] rt, rd;
  logic       stall, flush;
  logic [4:0] rs_chk, rt_chk;
  logic [4:0] dest_out;
  logic       we_out, valid_out;
  logic       hazard_rs, hazard_rt;
  logic [1:0] dist_rs, dist_rt;

  dest_reg_pipe #(.ADDR_W(5), .STAGES(3), .LINK_REG(31), .DIST_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .reg_dst(reg_dst),
    .reg_write(reg_write), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
    .rs_chk(rs_chk), .rt_chk(rt_chk), .dest_out(dest_out), .we_out(we_out),
    .valid_out(valid_out), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
    .dist_rs(dist_rs), .dist_rt(dist_rt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] d;
  } stg_t;

  typedef struct {
    logic       v;
    logic [1:0] dst;
    logic       wr;
    logic [4:0] rt;
    logic [4:0] rd;
    stg_t       exp;
  } vec_t;

  localparam stg_t BUB = '{v: 1'b0, we: 1'b0, d: 5'd0};

  // scoreboard holds expected stage contents, oldest (write-back) first
  stg_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] dst, input logic wr,
                       input logic [4:0] t, input logic [4:0] d);
    valid_in  = v;
    reg_dst   = dst;
    reg_write = wr;
    rt        = t;
    rd        = d;
  endtask

  task automatic chk_out(input string name);
    chk({name, ".valid"}, 32'(valid_out), 32'(sb[0].v));
    chk({name, ".we"},    32'(we_out),    32'(sb[0].we));
    chk({name, ".dest"},  32'(dest_out),  32'(sb[0].d));
  endtask

  // one advancing edge: the pipe moves forward and x enters stage 1
  task automatic advance(input stg_t x, input string name);
    tick();
    void'(sb.pop_front());
    sb.push_back(x);
    chk_out(name);
  endtask

  task automatic sb_reset();
    sb.delete();
    repeat (3) sb.push_back(BUB);
  endtask

  task automatic chk_haz(input string name, input logic hr, input logic [1:0] dr,
                         input logic ht, input logic [1:0] dt);
    chk({name, ".hazard_rs"}, 32'(hazard_rs), 32'(hr));
    chk({name, ".dist_rs"},   32'(dist_rs),   32'(dr));
    chk({name, ".hazard_rt"}, 32'(hazard_rt), 32'(ht));
    chk({name, ".dist_rt"},   32'(dist_rt),   32'(dt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 2'b00, 1'b1, 5'd10, 5'd31, '{1'b1, 1'b1, 5'd10}};
    tbl[1] = '{1'b1, 2'b01, 1'b1, 5'd10, 5'd31, '{1'b1, 1'b1, 5'd31}};
    tbl[2] = '{1'b1, 2'b10, 1'b1, 5'd10, 5'd31, '{1'b1, 1'b1, 5'd31}};
    tbl[3] = '{1'b1, 2'b11, 1'b1, 5'd10, 5'd31, '{1'b1, 1'b0, 5'd0}};
    tbl[4] = '{1'b1, 2'b00, 1'b1, 5'd0,  5'd31, '{1'b1, 1'b0, 5'd0}};
    tbl[5] = '{1'b0, 2'b01, 1'b1, 5'd4,  5'd9,  '{1'b0, 1'b0, 5'd0}};
    tbl[6] = '{1'b1, 2'b01, 1'b1, 5'd4,  5'd1,  '{1'b1, 1'b1, 5'd1}};
    tbl[7] = '{1'b1, 2'b10, 1'b1, 5'd0,  5'd0,  '{1'b1, 1'b1, 5'd31}};
    tbl[8] = '{1'b1, 2'b00, 1'b1, 5'd17, 5'd2,  '{1'b1, 1'b1, 5'd17}};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 2'b01, 1'b1, 5'd3, 5'd5);
    rs_chk = 5'd5; rt_chk = 5'd3;

    // reset with a live instruction at the input
    tick();
    sb_reset();
    chk_out("reset");
    chk_haz("reset", 1'b0, 2'd0, 1'b0, 2'd0);

    // mux table; rs_chk stays 0 so hazard_rs must stay low throughout
    rst_n = 1'b1;
    rs_chk = 5'd0; rt_chk = 5'd0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].dst, tbl[i].wr, tbl[i].rt, tbl[i].rd);
      advance(tbl[i].exp, $sformatf("mux%0d", i));
      chk($sformatf("mux%0d.hazard_rs_zero", i), 32'(hazard_rs), 32'd0);
    end
    drive(1'b0, 2'b00, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) advance(BUB, $sformatf("drain_a%0d", i));

    // hazard distance: stages become s1=8, s2=9, s3=8
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd8); advance('{1'b1, 1'b1, 5'd8}, "haz_i0");
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd9); advance('{1'b1, 1'b1, 5'd9}, "haz_i1");
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd8); advance('{1'b1, 1'b1, 5'd8}, "haz_i2");
    rs_chk = 5'd8; rt_chk = 5'd9;
    #1 chk_haz("haz", 1'b1, 2'd1, 1'b1, 2'd2);
    rs_chk = 5'd7;
    #1 chk_haz("haz_miss", 1'b0, 2'd0, 1'b1, 2'd2);
    rs_chk = 5'd8;

    // stall two cycles with a fresh instruction waiting at the input
    stall = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd20);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i));
      chk_haz($sformatf("stall%0d", i), 1'b1, 2'd1, 1'b1, 2'd2);
    end
    stall = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 5'd0, 5'd0);
    advance(BUB, "drain_b0");
    chk_haz("drain_b0", 1'b1, 2'd2, 1'b1, 2'd3);
    advance(BUB, "drain_b1");
    chk_haz("drain_b1", 1'b1, 2'd3, 1'b0, 2'd0);
    advance(BUB, "drain_b2");
    chk_haz("drain_b2", 1'b0, 2'd0, 1'b0, 2'd0);

    // flush together with stall: rd=12 must become a bubble, older stages advance
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd3); advance('{1'b1, 1'b1, 5'd3}, "fl_i0");
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd4); advance('{1'b1, 1'b1, 5'd4}, "fl_i1");
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd12);
    stall = 1'b1; flush = 1'b1;
    rs_chk = 5'd12; rt_chk = 5'd4;
    advance(BUB, "flush");
    chk_haz("flush", 1'b0, 2'd0, 1'b1, 2'd2);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) advance(BUB, $sformatf("drain_c%0d", i));

    // reset mid-stream discards everything in flight
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd6); advance('{1'b1, 1'b1, 5'd6}, "rm_i0");
    drive(1'b1, 2'b01, 1'b1, 5'd0, 5'd7); advance('{1'b1, 1'b1, 5'd7}, "rm_i1");
    rst_n = 1'b0;
    rs_chk = 5'd6; rt_chk = 5'd7;
    tick();
    sb_reset();
    chk_out("reset_mid");
    chk_haz("reset_mid", 1'b0, 2'd0, 1'b0, 2'd0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) advance(BUB, $sformatf("drain_d%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
